// File: rtl/dout_event_fifo.sv
// dout_event_fifo: classifies counter LOAD/WRAP events and buffers them in a first-word-fall-through FIFO
module dout_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK_w,
  input  logic             RST,
  input  logic             SEL_w,
  input  logic [WIDTH-1:0] CNT,
  input  logic             CLR,
  output logic             EV_VALID,
  input  logic             EV_READY,
  output logic [WIDTH+1:0] EV_DATA,
  output logic [AW:0]      LEVEL,
  output logic             OVF,
  output logic [7:0]       OVF_CNT
);
  logic             sel_d;
  logic [WIDTH-1:0] prev_cnt;
  logic [AW-1:0]    wr, rd;
  logic [WIDTH+1:0] mem [DEPTH];
  logic [WIDTH+1:0] last;
  logic [1:0]       typ;
  logic             push, pop, full, accept, drop;
  always_comb begin
    typ    = sel_d ? 2'b01 : (&prev_cnt && CNT == '0) ? 2'b10 : 2'b00;
    push   = typ != 2'b00;
    pop    = EV_VALID && EV_READY;
    full   = LEVEL == (AW+1)'(DEPTH);
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end
  assign EV_VALID = LEVEL != '0;
  // the last popped entry keeps EV_DATA stable while the FIFO is empty
  assign EV_DATA  = EV_VALID ? mem[rd] : last;
  always_ff @(posedge CLK_w or negedge RST)
    if (!RST) begin
      sel_d    <= 1'b0;
      prev_cnt <= '0;
      wr       <= '0;
      rd       <= '0;
      last     <= '0;
      LEVEL    <= '0;
      OVF      <= 1'b0;
      OVF_CNT  <= 8'd0;
    end else begin
      sel_d    <= SEL_w;
      prev_cnt <= CNT;
      if (accept) wr <= wr + AW'(1);
      if (pop) begin
        rd   <= rd + AW'(1);
        last <= mem[rd];
      end
      LEVEL   <= LEVEL + (AW+1)'(accept) - (AW+1)'(pop);
      OVF     <= drop || (OVF && !CLR);
      OVF_CNT <= drop ? (CLR ? 8'd1 : OVF_CNT + 8'(OVF_CNT != 8'hFF)) : CLR ? 8'd0 : OVF_CNT;
    end
  always_ff @(posedge CLK_w)
    if (accept) mem[wr] <= {typ, CNT};
endmodule

// File: tb/tb_dout_event_fifo.sv
// tb_dout_event_fifo: queue-based reference model with per-cycle compare, directed scenarios and random traffic
module tb_dout_event_fifo;
  logic       CLK_w = 0, RST = 0, SEL_w = 0, CLR = 0, EV_READY = 1, run = 0;
  logic [3:0] din = 0, cnt_u;
  logic       EV_VALID, OVF;
  logic [5:0] EV_DATA;
  logic [3:0] LEVEL;
  logic [7:0] OVF_CNT;
  int ncmp = 0, nerr = 0;

  dout_event_fifo dut (
    .CLK_w(CLK_w), .RST(RST), .SEL_w(SEL_w), .CNT(cnt_u), .CLR(CLR),
    .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_DATA(EV_DATA),
    .LEVEL(LEVEL), .OVF(OVF), .OVF_CNT(OVF_CNT)
  );

  always #5 CLK_w = ~CLK_w;

  // upstream load/increment counter
  always @(posedge CLK_w) cnt_u <= !RST ? 4'd0 : SEL_w ? din : run ? cnt_u + 4'd1 : cnt_u;

  task automatic chk(input string n, input int a, input int e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  logic [5:0] q[$];
  logic       ms = 0;
  logic [3:0] mp = 0;
  logic       mo = 0;
  int         mc = 0;
  logic [5:0] ml = 0;
  int         t;
  bit         mfull, mpop;

  always @(posedge CLK_w or negedge RST)
    if (!RST) begin
      q.delete();
      ms = 0; mp = 0; mo = 0; mc = 0; ml = 0;
    end else begin
      t     = ms ? 1 : (mp == 4'hF && cnt_u == 4'h0) ? 2 : 0;
      mfull = q.size() == 8;
      mpop  = q.size() != 0 && EV_READY;
      if (mpop) begin
        ml = q[0];
        void'(q.pop_front());
      end
      if (t != 0 && (!mfull || mpop)) q.push_back({2'(t), cnt_u});
      if (t != 0 && mfull && !mpop) begin
        mo = 1;
        mc = CLR ? 1 : (mc < 255 ? mc + 1 : 255);
      end else if (CLR) begin
        mo = 0;
        mc = 0;
      end
      ms = SEL_w;
      mp = cnt_u;
    end

  always @(negedge CLK_w) begin
    chk("valid", EV_VALID, q.size() != 0);
    chk("data", EV_DATA, q.size() != 0 ? q[0] : ml);
    chk("level", LEVEL, q.size());
    chk("ovf", OVF, mo);
    chk("ovf_cnt", OVF_CNT, mc);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_w);
  endtask

  task automatic load(input logic [3:0] v);
    SEL_w = 1;
    din   = v;
    @(negedge CLK_w);
    SEL_w = 0;
  endtask

  initial begin
    int nv;
    logic [5:0] d;
    cyc(2);
    chk("rst_valid", EV_VALID, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_data", EV_DATA, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_ovf_cnt", OVF_CNT, 0);
    RST = 1;
    // free-running wrap
    run = 1; nv = 0; d = 0;
    for (int i = 0; i < 22; i++) begin
      cyc(1);
      if (i == 17) run = 0;
      if (EV_VALID) begin nv++; d = EV_DATA; end
    end
    chk("wrap_count", nv, 1);
    chk("wrap_data", d, 6'h20);
    // single load latency
    load(4'hA);
    chk("load_lat1", EV_VALID, 0);
    cyc(1);
    chk("load_lat2", EV_VALID, 1);
    chk("load_data", EV_DATA, 6'h1A);
    cyc(1);
    chk("load_popped", LEVEL, 0);
    // overflow with 10 loads
    EV_READY = 0;
    for (int v = 1; v <= 10; v++) load(4'(v));
    cyc(2);
    chk("ovf_level", LEVEL, 8);
    chk("ovf_flag", OVF, 1);
    chk("ovf_count", OVF_CNT, 2);
    EV_READY = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", EV_DATA, 6'h10 + i);
      cyc(1);
    end
    chk("drain_empty", EV_VALID, 0);
    // full with simultaneous push and pop
    EV_READY = 0;
    for (int v = 1; v <= 8; v++) load(4'(v));
    cyc(2);
    chk("full_level", LEVEL, 8);
    load(4'hC);
    EV_READY = 1;
    cyc(1);
    EV_READY = 0;
    chk("pushpop_level", LEVEL, 8);
    chk("pushpop_ovf_cnt", OVF_CNT, 2);
    EV_READY = 1;
    for (int i = 0; i < 8; i++) begin
      chk("pushpop_drain", EV_DATA, i < 7 ? 6'h10 + i + 2 : 6'h1C);
      cyc(1);
    end
    chk("pushpop_empty", EV_VALID, 0);
    // load of 0 after F is LOAD only
    load(4'hF);
    load(4'h0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (EV_VALID) begin nv++; d = EV_DATA; end
      cyc(1);
    end
    chk("f0_count", nv, 2);
    chk("f0_data", d, 6'h10);
    // clear coincident with overflow
    EV_READY = 0;
    for (int v = 1; v <= 9; v++) load(4'(v));
    CLR = 1;
    cyc(1);
    CLR = 0;
    chk("clr_ovf", OVF, 1);
    chk("clr_ovf_cnt", OVF_CNT, 1);
    // asynchronous reset mid-operation
    EV_READY = 1;
    cyc(10);
    EV_READY = 0;
    for (int v = 1; v <= 5; v++) load(4'(v));
    cyc(2);
    chk("pre_rst_level", LEVEL, 5);
    #2 RST = 0;
    #1;
    chk("arst_valid", EV_VALID, 0);
    chk("arst_level", LEVEL, 0);
    chk("arst_ovf", OVF, 0);
    chk("arst_ovf_cnt", OVF_CNT, 0);
    cyc(2);
    RST = 1;
    EV_READY = 1;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (EV_VALID) nv++;
    end
    chk("post_rst_quiet", nv, 0);
    // random traffic; phase 0 never pops, driving the drop counter to saturation
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < (p == 0 ? 1200 : 800); i++) begin
        SEL_w    = $urandom_range(0, 1) == 0;
        din      = 4'($urandom);
        run      = $urandom_range(0, 3) != 0;
        EV_READY = $urandom_range(0, 3) < p;
        CLR      = p != 0 && $urandom_range(0, 63) == 0;
        cyc(1);
      end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
